action_sequencer: RTL and testbench
===================================

ACTION_SEQUENCER -- requirements
Module: action_sequencer

Interface
REQ-001 SHALL have parameter ATK_STARTUP, default 3, meaning attack wind-up length in frames (≥1).
REQ-002 SHALL have parameter ATK_ACTIVE, default 4, meaning frames with hitbox enabled (≥1).
REQ-003 SHALL have parameter ATK_RECOVER, default 6, meaning attack recovery frames (≥1).
REQ-004 SHALL have parameter STUN_FRAMES, default 10, meaning hit-stun length in frames (≥1).
REQ-005 SHALL have parameter CNT_WIDTH, default 5, meaning frame-counter width; every frame parameter SHALL be ≤ 2^CNT_WIDTH-1.
REQ-006 SHALL have ports: clk input 1 system clock; reset input 1 asynchronous active-high reset.
REQ-007 SHALL have ports: SCEN input 1 frame-tick enable, one clk wide; btn_left, btn_right, btn_jump, btn_attack, btn_block input 1 each, raw level controls.
REQ-008 SHALL have ports: jump_active input 1 movement unit airborne flag; hit_in input 1 opponent-hit flag, held until next SCEN.
REQ-009 SHALL have ports: move_left, move_right, jump output 1 each, movement-unit commands; attack_active output 1 hitbox enable; block_active output 1 guard flag; state output 3 current state code; busy output 1 high in any state other than IDLE.

Function
REQ-010 SHALL change state, counter, edge history and every output only on clk edges where SCEN=1; outputs SHALL be registered.
REQ-011 SHALL sample btn_jump and btn_attack on SCEN and detect rising edges against the value sampled at the previous SCEN.
REQ-012 SHALL implement states IDLE=0, JUMP=1, ATK_SU=2, ATK_ACT=3, ATK_REC=4, BLOCK=5, STUN=6; code 7 SHALL be unreachable and SHALL return to IDLE on the next SCEN.
REQ-013 In IDLE, the next state SHALL be chosen by priority: hit_in -> STUN; attack edge -> ATK_SU; jump edge -> JUMP; btn_block=1 -> BLOCK; otherwise stay in IDLE.
REQ-014 In IDLE with no transition, move_left SHALL be btn_left AND NOT btn_right, and move_right SHALL be btn_right AND NOT btn_left; with both buttons pressed, neither output SHALL be driven.
REQ-015 On the IDLE->JUMP transition, jump SHALL be high for exactly one frame; move_left/move_right SHALL carry the current direction in that same frame so the take-off drift is latched downstream.
REQ-016 In JUMP, move and jump outputs SHALL be low; the block SHALL return to IDLE on the first SCEN at which jump_active=0, but not on the frame immediately after entry.
REQ-017 Each of ATK_SU, ATK_ACT, ATK_REC and STUN SHALL last exactly its parameter count in frames, via a down-counter loaded on entry; on count expiry ATK_SU->ATK_ACT->ATK_REC->IDLE and STUN->IDLE.
REQ-018 attack_active SHALL be 1 only in ATK_ACT; move and jump outputs SHALL be 0 in all attack states and STUN.
REQ-019 BLOCK SHALL hold block_active=1 and remain while btn_block=1; it SHALL exit to IDLE on the SCEN with btn_block=0.
REQ-020 hit_in in BLOCK SHALL be ignored.
REQ-021 hit_in in any state other than BLOCK SHALL enter STUN and reload the counter, including during STUN, where the stun restarts; an attack in progress SHALL be cancelled.
REQ-022 Button edges arriving during a non-IDLE state SHALL be discarded, not queued.
REQ-023 hit_in and an attack edge on the same SCEN SHALL resolve to STUN.

Reset
REQ-024 Asserting reset SHALL, immediately and regardless of SCEN: set the state to IDLE, clear the counter, clear the edge history to 0, and drive all outputs to 0 (state=0, busy=0).
REQ-025 Reset asserted mid-attack or mid-stun SHALL abandon the action; the first SCEN after reset SHALL evaluate from IDLE.

Verification
REQ-026 Bench SHALL cover: btn_attack 0->1 in IDLE (defaults) -> 3 frames ATK_SU, 4 frames attack_active=1, 6 frames ATK_REC, then IDLE with busy=0, for 13 frames total.
REQ-027 Bench SHALL cover: btn_jump rising with btn_right=1 -> one frame jump=1 and move_right=1; with jump_active high for 16 frames and then low -> state 1 throughout, IDLE on the SCEN after jump_active falls.
REQ-028 Bench SHALL cover: hit_in during ATK_ACT frame 2 -> attack_active drops next frame, 10 frames STUN; a second hit_in at stun frame 5 -> 10 more frames from reload.
REQ-029 Bench SHALL cover: btn_block held, hit_in pulsed -> state stays 5 and block_active=1; releasing block -> IDLE next SCEN.
REQ-030 Bench SHALL cover: btn_left=btn_right=1 in IDLE -> move_left=move_right=0; SCEN held low for 20 clks with button toggles -> no output change.
REQ-031 Bench SHALL cover: reset asserted between SCENs during ATK_REC -> all outputs 0 within the same cycle; an attack edge at the first SCEN after release -> ATK_SU.

Source files
------------

// File: rtl/action_sequencer_if.sv
// action_sequencer_if: frame-tick, control and command signals between game logic and the action sequencer
interface action_sequencer_if;
  logic       SCEN;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
  logic       btn_attack;
  logic       btn_block;
  logic       jump_active;
  logic       hit_in;
  logic       move_left;
  logic       move_right;
  logic       jump;
  logic       attack_active;
  logic       block_active;
  logic [2:0] state;
  logic       busy;
  modport master (
    output SCEN, btn_left, btn_right, btn_jump, btn_attack, btn_block, jump_active, hit_in,
    input  move_left, move_right, jump, attack_active, block_active, state, busy
  );
  modport slave (
    input  SCEN, btn_left, btn_right, btn_jump, btn_attack, btn_block, jump_active, hit_in,
    output move_left, move_right, jump, attack_active, block_active, state, busy
  );
endinterface

// File: rtl/action_sequencer.sv
// action_sequencer: frame-ticked character action FSM (move, jump, attack, block, hit-stun)
module action_sequencer #(
  parameter int ATK_STARTUP = 3,
  parameter int ATK_ACTIVE  = 4,
  parameter int ATK_RECOVER = 6,
  parameter int STUN_FRAMES = 10,
  parameter int CNT_WIDTH   = 5
) (
  input logic clk,
  input logic reset,
  action_sequencer_if.slave a
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    JUMP    = 3'd1,
    ATK_SU  = 3'd2,
    ATK_ACT = 3'd3,
    ATK_REC = 3'd4,
    BLOCK   = 3'd5,
    STUN    = 3'd6,
    BAD     = 3'd7
  } state_t;
  state_t st, nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic jmp_q, atk_q;
  logic jmp_edge, atk_edge, dir_l, dir_r;
  logic ml_n, mr_n, j_n;
  logic cnt_zero;
  assign jmp_edge = a.btn_jump & ~jmp_q;
  assign atk_edge = a.btn_attack & ~atk_q;
  assign dir_l    = a.btn_left & ~a.btn_right;
  assign dir_r    = a.btn_right & ~a.btn_left;
  assign cnt_zero = cnt == '0;
  assign a.state  = st;
  // next state, counter and per-frame move/jump commands; hit preempts everything except a guard
  always_comb begin
    nxt     = st;
    cnt_nxt = cnt_zero ? '0 : cnt - CNT_WIDTH'(1);
    ml_n    = 1'b0;
    mr_n    = 1'b0;
    j_n     = 1'b0;
    if (a.hit_in && st != BLOCK) begin
      nxt     = STUN;
      cnt_nxt = CNT_WIDTH'(STUN_FRAMES - 1);
    end else begin
      case (st)
        IDLE: begin
          cnt_nxt = '0;
          if (atk_edge) begin
            nxt     = ATK_SU;
            cnt_nxt = CNT_WIDTH'(ATK_STARTUP - 1);
          end else if (jmp_edge) begin
            nxt     = JUMP;
            cnt_nxt = CNT_WIDTH'(1);
            j_n     = 1'b1;
            ml_n    = dir_l;
            mr_n    = dir_r;
          end else if (a.btn_block) begin
            nxt = BLOCK;
          end else begin
            ml_n = dir_l;
            mr_n = dir_r;
          end
        end
        JUMP:    nxt = (cnt_zero && !a.jump_active) ? IDLE : JUMP;
        ATK_SU: begin
          nxt     = cnt_zero ? ATK_ACT : ATK_SU;
          cnt_nxt = cnt_zero ? CNT_WIDTH'(ATK_ACTIVE - 1) : cnt_nxt;
        end
        ATK_ACT: begin
          nxt     = cnt_zero ? ATK_REC : ATK_ACT;
          cnt_nxt = cnt_zero ? CNT_WIDTH'(ATK_RECOVER - 1) : cnt_nxt;
        end
        ATK_REC: nxt = cnt_zero ? IDLE : ATK_REC;
        STUN:    nxt = cnt_zero ? IDLE : STUN;
        BLOCK: begin
          nxt     = a.btn_block ? BLOCK : IDLE;
          cnt_nxt = '0;
        end
        default: begin
          nxt     = IDLE;
          cnt_nxt = '0;
        end
      endcase
    end
  end
  // state, counter, edge history and registered outputs advance only on frame ticks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st              <= IDLE;
      cnt             <= '0;
      jmp_q           <= 1'b0;
      atk_q           <= 1'b0;
      a.move_left     <= 1'b0;
      a.move_right    <= 1'b0;
      a.jump          <= 1'b0;
      a.attack_active <= 1'b0;
      a.block_active  <= 1'b0;
      a.busy          <= 1'b0;
    end else if (a.SCEN) begin
      st              <= nxt;
      cnt             <= cnt_nxt;
      jmp_q           <= a.btn_jump;
      atk_q           <= a.btn_attack;
      a.move_left     <= ml_n;
      a.move_right    <= mr_n;
      a.jump          <= j_n;
      a.attack_active <= nxt == ATK_ACT;
      a.block_active  <= nxt == BLOCK;
      a.busy          <= nxt != IDLE;
    end
  end
endmodule

// File: tb/tb_action_sequencer.sv
// tb_action_sequencer: directed and randomized frame-level checks against an elapsed-frame reference model
module tb_action_sequencer;
  localparam int SU = 3, ACT = 4, REC = 6, STN = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  action_sequencer_if bus ();
  action_sequencer #(.ATK_STARTUP(SU), .ATK_ACTIVE(ACT), .ATK_RECOVER(REC), .STUN_FRAMES(STN), .CNT_WIDTH(5))
    dut (.clk(clk), .reset(reset), .a(bus));
  always #5 clk = ~clk;
  int passes = 0;
  int checks = 0;
  int m_state, m_age;
  logic m_pj, m_pa, e_ml, e_mr, e_j;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  function automatic int dur(input int s);
    return s == 2 ? SU : s == 3 ? ACT : s == 4 ? REC : STN;
  endfunction
  task automatic model_reset();
    m_state = 0; m_age = 0; m_pj = 0; m_pa = 0; e_ml = 0; e_mr = 0; e_j = 0;
  endtask
  task automatic enter(input int s);
    m_state = s;
    m_age = 0;
  endtask
  task automatic model_step(input logic l, r, j, at, b, h, ja);
    logic je, ae;
    je = j & ~m_pj;
    ae = at & ~m_pa;
    m_pj = j;
    m_pa = at;
    e_ml = 0; e_mr = 0; e_j = 0;
    if (h && m_state != 5) enter(6);
    else if (m_state == 0) begin
      if (ae) enter(2);
      else if (je) begin
        enter(1);
        e_j = 1; e_ml = l & ~r; e_mr = r & ~l;
      end else if (b) enter(5);
      else begin
        e_ml = l & ~r; e_mr = r & ~l;
      end
    end else if (m_state == 1) begin
      if (m_age >= 1 && !ja) enter(0);
      else m_age++;
    end else if (m_state == 5) begin
      if (!b) enter(0);
    end else begin
      if (m_age + 1 == dur(m_state)) enter(m_state == 2 ? 3 : m_state == 3 ? 4 : 0);
      else m_age++;
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".state"}, 8'(bus.state), 8'(m_state));
    chk({tag, ".move_left"}, 8'(bus.move_left), 8'(e_ml));
    chk({tag, ".move_right"}, 8'(bus.move_right), 8'(e_mr));
    chk({tag, ".jump"}, 8'(bus.jump), 8'(e_j));
    chk({tag, ".attack_active"}, 8'(bus.attack_active), 8'(m_state == 3));
    chk({tag, ".block_active"}, 8'(bus.block_active), 8'(m_state == 5));
    chk({tag, ".busy"}, 8'(bus.busy), 8'(m_state != 0));
  endtask
  task automatic frame(input string tag, input logic l, r, j, at, b, h, ja);
    bus.btn_left = l; bus.btn_right = r; bus.btn_jump = j; bus.btn_attack = at;
    bus.btn_block = b; bus.hit_in = h; bus.jump_active = ja;
    bus.SCEN = 1'b1;
    @(posedge clk);
    #1 bus.SCEN = 1'b0;
    model_step(l, r, j, at, b, h, ja);
    check_all(tag);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, ".state"}, 8'(bus.state), 8'd0);
    chk({tag, ".outs"}, {2'b0, bus.move_left, bus.move_right, bus.jump, bus.attack_active, bus.block_active, bus.busy}, 8'd0);
  endtask
  initial begin
    int n_su, n_act, n_rec, tot, n;
    bus.SCEN = 0; bus.btn_left = 0; bus.btn_right = 0; bus.btn_jump = 0; bus.btn_attack = 0;
    bus.btn_block = 0; bus.hit_in = 0; bus.jump_active = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    // attack sequence with default timings
    frame("atk0", 0, 0, 0, 1, 0, 0, 0);
    n_su = bus.state == 3'd2 ? 1 : 0; n_act = 0; n_rec = 0; tot = 1;
    for (int i = 0; i < 30 && bus.busy; i++) begin
      frame("atk", 0, 0, 0, 1, 0, 0, 0);
      if (bus.state == 3'd2) n_su++;
      if (bus.attack_active) n_act++;
      if (bus.state == 3'd4) n_rec++;
      if (bus.busy) tot++;
    end
    chk("atk_startup_frames", 8'(n_su), 8'(SU));
    chk("atk_active_frames", 8'(n_act), 8'(ACT));
    chk("atk_recover_frames", 8'(n_rec), 8'(REC));
    chk("atk_total_frames", 8'(tot), 8'd13);
    chk("atk_end_busy", 8'(bus.busy), 8'd0);
    frame("rel", 0, 0, 0, 0, 0, 0, 0);
    // jump with rightward drift
    frame("jmp0", 0, 1, 1, 0, 0, 0, 0);
    chk("jmp_pulse", 8'(bus.jump), 8'd1);
    chk("jmp_drift_right", 8'(bus.move_right), 8'd1);
    for (int i = 0; i < 16; i++) begin
      frame("jmp_air", 0, 1, 1, 0, 0, 0, 1);
      chk("jmp_state", 8'(bus.state), 8'd1);
    end
    frame("jmp_land", 0, 0, 0, 0, 0, 0, 0);
    chk("jmp_landed", 8'(bus.state), 8'd0);
    // hit during active frames, then restart stun mid-way
    frame("hs0", 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < SU + 1; i++) frame("hs_wind", 0, 0, 0, 1, 0, 0, 0);
    chk("hs_act2", 8'(bus.attack_active), 8'd1);
    frame("hs_hit", 0, 0, 0, 1, 0, 1, 0);
    chk("hs_drop", 8'(bus.attack_active), 8'd0);
    chk("hs_stun", 8'(bus.state), 8'd6);
    for (int i = 0; i < 4; i++) frame("hs_stun", 0, 0, 0, 0, 0, 0, 0);
    frame("hs_rehit", 0, 0, 0, 0, 0, 1, 0);
    n = 1;
    while (bus.state == 3'd6 && n < 40) begin
      frame("hs_cnt", 0, 0, 0, 0, 0, 0, 0);
      if (bus.state == 3'd6) n++;
    end
    chk("stun_reload_frames", 8'(n), 8'(STN));
    // guard absorbs hits
    frame("blk0", 0, 0, 0, 0, 1, 0, 0);
    frame("blk_hit", 0, 0, 0, 0, 1, 1, 0);
    chk("blk_state", 8'(bus.state), 8'd5);
    chk("blk_active", 8'(bus.block_active), 8'd1);
    frame("blk_rel", 0, 0, 0, 0, 0, 0, 0);
    chk("blk_exit", 8'(bus.state), 8'd0);
    // opposing directions cancel; no change without a frame tick
    frame("both", 1, 1, 0, 0, 0, 0, 0);
    chk("both_left", 8'(bus.move_left), 8'd0);
    chk("both_right", 8'(bus.move_right), 8'd0);
    for (int i = 0; i < 20; i++) begin
      bus.btn_left = 1'($urandom_range(0, 1)); bus.btn_right = 1'($urandom_range(0, 1));
      bus.btn_jump = 1'($urandom_range(0, 1)); bus.btn_attack = 1'($urandom_range(0, 1));
      bus.hit_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1 check_all("noscen");
    end
    frame("clr", 0, 0, 0, 0, 0, 0, 0);
    // async reset in recovery abandons the attack
    frame("rs0", 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < SU + ACT + 1; i++) frame("rs_run", 0, 0, 0, 1, 0, 0, 0);
    chk("rs_in_rec", 8'(bus.state), 8'd4);
    #2 reset = 1'b1;
    #1 check_zero("rs_async");
    model_reset();
    bus.btn_attack = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    frame("rs_atk", 0, 0, 0, 1, 0, 0, 0);
    chk("rs_atk_su", 8'(bus.state), 8'd2);
    // randomized frames against the reference model
    for (int i = 0; i < 400; i++)
      frame("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 3) != 0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
